// File: rtl/request_unit.sv
// Sequences instruction fetch and data requests for a single-issue core, with sticky halt/error flags and saturating perf counters.
// Latency: non-memory instruction retires (pcEn) in the ihit cycle; memory instruction retires in the dhit cycle.
// Backpressure: ihit/dhit act as ready; the unit holds state and enables until the selected cache responds.
module request_unit #(
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             memRead,
    input  logic             memWrite,
    input  logic             halt,
    input  logic             ihit,
    input  logic             dhit,
    output logic             imemREN,
    output logic             dmemREN,
    output logic             dmemWEN,
    output logic             pcEn,
    output logic             halted,
    output logic             memErr,
    output logic [CNT_W-1:0] dreqCount,
    output logic [CNT_W-1:0] stallCount
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        DATA  = 2'd1,
        HALT  = 2'd2
    } state_t;

    state_t state, state_nxt;
    logic   latch_req;
    logic   dreq_inc;
    logic   stall_inc;

    always_comb begin
        state_nxt = state;
        pcEn      = 1'b0;
        latch_req = 1'b0;
        dreq_inc  = 1'b0;
        case (state)
            FETCH: begin
                if (ihit) begin
                    if (halt) begin
                        state_nxt = HALT;
                    end else if (memRead || memWrite) begin
                        state_nxt = DATA;
                        latch_req = 1'b1;
                    end else begin
                        pcEn = 1'b1;
                    end
                end
            end
            DATA: begin
                if (dhit) begin
                    state_nxt = FETCH;
                    pcEn      = 1'b1;
                    dreq_inc  = 1'b1;
                end
            end
            HALT: begin
                state_nxt = HALT;
            end
            default: begin
                state_nxt = FETCH;
            end
        endcase
        // Reset wins over any response arriving in the same cycle: nothing retires.
        if (RST) begin
            pcEn = 1'b0;
        end
        stall_inc = (state == FETCH || state == DATA) && !pcEn;
    end

    assign imemREN = (state == FETCH);
    assign halted  = (state == HALT);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= FETCH;
            dmemREN    <= 1'b0;
            dmemWEN    <= 1'b0;
            memErr     <= 1'b0;
            dreqCount  <= '0;
            stallCount <= '0;
        end else begin
            state <= state_nxt;
            // A conflicting read+write request is issued as a write and flagged.
            if (latch_req) begin
                dmemWEN <= memWrite;
                dmemREN <= memRead && !memWrite;
                if (memRead && memWrite) begin
                    memErr <= 1'b1;
                end
            end else if (state != DATA || dhit) begin
                dmemREN <= 1'b0;
                dmemWEN <= 1'b0;
            end
            if (dreq_inc && dreqCount != {CNT_W{1'b1}}) begin
                dreqCount <= dreqCount + CNT_W'(1);
            end
            if (stall_inc && stallCount != {CNT_W{1'b1}}) begin
                stallCount <= stallCount + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_request_unit.sv
// Directed-vector bench for request_unit: a 16-bit counter instance plus a 4-bit instance for saturation.
module tb_request_unit;

    logic        CLK = 1'b0;
    logic        RST;
    logic        memRead, memWrite, halt, ihit, dhit;
    logic        imemREN, dmemREN, dmemWEN, pcEn, halted, memErr;
    logic [15:0] dreqCount, stallCount;
    logic        s_imemREN, s_dmemREN, s_dmemWEN, s_pcEn, s_halted, s_memErr;
    logic [3:0]  s_dreqCount, s_stallCount;

    int checks   = 0;
    int failures = 0;

    always #5 CLK = ~CLK;

    request_unit #(.CNT_W(16)) dut (
        .CLK(CLK), .RST(RST), .memRead(memRead), .memWrite(memWrite), .halt(halt),
        .ihit(ihit), .dhit(dhit), .imemREN(imemREN), .dmemREN(dmemREN), .dmemWEN(dmemWEN),
        .pcEn(pcEn), .halted(halted), .memErr(memErr), .dreqCount(dreqCount),
        .stallCount(stallCount)
    );

    request_unit #(.CNT_W(4)) dut_small (
        .CLK(CLK), .RST(RST), .memRead(memRead), .memWrite(memWrite), .halt(halt),
        .ihit(ihit), .dhit(dhit), .imemREN(s_imemREN), .dmemREN(s_dmemREN), .dmemWEN(s_dmemWEN),
        .pcEn(s_pcEn), .halted(s_halted), .memErr(s_memErr), .dreqCount(s_dreqCount),
        .stallCount(s_stallCount)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle's inputs, then wait for the falling edge where outputs are sampled.
    task automatic drive(input logic r, input logic ih, input logic dh,
                         input logic rd, input logic wr, input logic hl);
        RST = r; ihit = ih; dhit = dh; memRead = rd; memWrite = wr; halt = hl;
        @(negedge CLK);
    endtask

    task automatic next_cycle();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        RST = 1'b1; ihit = 1'b0; dhit = 1'b0; memRead = 1'b0; memWrite = 1'b0; halt = 1'b0;
        next_cycle();

        // Reset held: FETCH, everything cleared, reset masks a simultaneous ihit+halt.
        drive(1, 1, 1, 0, 1, 1);
        chk("rst_imemREN", imemREN, 1);
        chk("rst_pcEn_masked", pcEn, 0);
        chk("rst_dmemWEN", dmemWEN, 0);
        chk("rst_halted", halted, 0);
        chk("rst_memErr", memErr, 0);
        chk("rst_dreq", dreqCount, 0);
        chk("rst_stall", stallCount, 0);
        next_cycle();
        drive(1, 0, 0, 0, 0, 0);
        chk("rst_prio_no_halt", halted, 0);
        chk("rst_prio_imemREN", imemREN, 1);
        next_cycle();

        // Three back-to-back non-memory instructions retire in their ihit cycle.
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 0, 0, 0, 0);
            chk("alu_pcEn", pcEn, 1);
            chk("alu_imemREN", imemREN, 1);
            next_cycle();
        end

        // Load: ihit cycle, two dhit=0 waits, dhit.
        drive(0, 1, 0, 1, 0, 0);
        chk("ld_cnt_dreq0", dreqCount, 0);
        chk("ld_cnt_stall0", stallCount, 0);
        chk("ld_latch_pcEn", pcEn, 0);
        chk("ld_latch_dmemREN", dmemREN, 0);
        next_cycle();
        drive(0, 0, 0, 0, 0, 0);
        chk("ld_wait1_dmemREN", dmemREN, 1);
        chk("ld_wait1_imemREN", imemREN, 0);
        chk("ld_wait1_pcEn", pcEn, 0);
        next_cycle();
        drive(0, 1, 0, 0, 0, 0);
        chk("ld_wait2_dmemREN", dmemREN, 1);
        chk("ld_wait2_pcEn_ihit_ignored", pcEn, 0);
        next_cycle();
        drive(0, 0, 1, 0, 0, 0);
        chk("ld_dhit_dmemREN", dmemREN, 1);
        chk("ld_dhit_pcEn", pcEn, 1);
        next_cycle();
        drive(0, 0, 0, 0, 0, 0);
        chk("ld_done_dmemREN", dmemREN, 0);
        chk("ld_done_imemREN", imemREN, 1);
        chk("ld_done_dreq", dreqCount, 1);
        chk("ld_done_stall", stallCount, 3);
        next_cycle();   // stall -> 4

        // Conflicting read+write: write only, sticky memErr; dhit in FETCH ignored.
        drive(0, 1, 1, 1, 1, 0);
        chk("err_latch_pcEn", pcEn, 0);
        chk("err_latch_memErr", memErr, 0);
        next_cycle();   // stall -> 5
        drive(0, 0, 0, 0, 0, 0);
        chk("err_dmemWEN", dmemWEN, 1);
        chk("err_dmemREN", dmemREN, 0);
        chk("err_memErr", memErr, 1);
        next_cycle();   // stall -> 6
        drive(0, 0, 1, 0, 0, 0);
        chk("err_dhit_pcEn", pcEn, 1);
        next_cycle();
        drive(0, 0, 0, 0, 0, 0);
        chk("err_done_dmemWEN", dmemWEN, 0);
        chk("err_sticky_memErr", memErr, 1);
        chk("err_done_dreq", dreqCount, 2);
        chk("err_done_stall", stallCount, 6);
        next_cycle();   // stall -> 7

        // Halt with a store: halt wins, then absorbing.
        drive(0, 1, 0, 0, 1, 1);
        chk("hlt_pcEn", pcEn, 0);
        next_cycle();   // stall -> 8
        drive(0, 1, 1, 0, 0, 0);
        chk("hlt_halted", halted, 1);
        chk("hlt_dmemWEN", dmemWEN, 0);
        chk("hlt_imemREN", imemREN, 0);
        chk("hlt_pcEn_pulse", pcEn, 0);
        next_cycle();
        drive(0, 1, 1, 1, 0, 0);
        chk("hlt_frozen_stall", stallCount, 8);
        chk("hlt_frozen_dreq", dreqCount, 2);
        chk("hlt_frozen_dmemREN", dmemREN, 0);
        next_cycle();
        drive(1, 0, 0, 0, 0, 0);
        chk("hlt_before_rst_edge", halted, 1);
        next_cycle();

        // Reset mid-store drops the request.
        drive(0, 1, 0, 0, 1, 0);
        chk("mid_rst_halted", halted, 0);
        chk("mid_rst_memErr", memErr, 0);
        chk("mid_rst_stall", stallCount, 0);
        next_cycle();
        drive(0, 0, 0, 0, 0, 0);
        chk("mid_dmemWEN", dmemWEN, 1);
        next_cycle();
        drive(1, 0, 1, 0, 0, 0);
        chk("mid_rst_dhit_pcEn", pcEn, 0);
        next_cycle();
        drive(0, 0, 0, 0, 0, 0);
        chk("mid_after_dmemWEN", dmemWEN, 0);
        chk("mid_after_imemREN", imemREN, 1);
        chk("mid_after_dreq", dreqCount, 0);
        chk("mid_after_stall", stallCount, 0);
        next_cycle();

        // Saturation: 20 stalled FETCH cycles.
        drive(1, 0, 0, 0, 0, 0);
        next_cycle();
        for (int i = 0; i < 20; i++) begin
            drive(0, 0, 0, 0, 0, 0);
            next_cycle();
        end
        drive(0, 0, 0, 0, 0, 0);
        chk("sat_small_stall", s_stallCount, 15);
        chk("sat_wide_stall", stallCount, 20);
        chk("sat_small_dreq", s_dreqCount, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        failures++;
        $display("FAIL timeout observed=running expected=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

endmodule
